block_move_writer: RTL and testbench

//  Write side of the block-record RAM that the draw FSM scans. Accepts one move request
//  (block index, direction), reads that block's record and checks board bounds. It then

---
 rtl/block_move_writer_pkg.sv | 32 +++
 rtl/block_move_writer_rect_overlap.sv | 26 ++
 rtl/block_move_writer.sv | 142 ++++++++++++++
 tb/tb_block_move_writer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/block_move_writer_pkg.sv
// block_move_writer_pkg: record layout, status codes, FSM states and board geometry defaults
package block_move_writer_pkg;
    localparam int NUM_BLOCKS_DEF = 16;
    localparam int STEP_DEF       = 11;
    localparam int BLK_LEN_DEF    = 11;
    localparam int BLK_W_DEF      = 4;
    localparam int GRID_X0_DEF    = 49;
    localparam int GRID_X1_DEF    = 115;
    localparam int GRID_Y0_DEF    = 49;
    localparam int GRID_Y1_DEF    = 115;

    localparam logic [2:0] EMPTY_COLOUR = 3'd0;

    typedef enum logic [1:0] {
        STATUS_MOVED   = 2'b00,
        STATUS_EDGE    = 2'b01,
        STATUS_COLLIDE = 2'b10,
        STATUS_EMPTY   = 2'b11
    } status_t;

    typedef struct packed {
        logic       pad;
        logic [2:0] colour;
        logic       orient;
        logic [6:0] y;
        logic [7:0] x;
    } record_t;

    typedef enum logic [2:0] {
        IDLE, ARB, RD_SELF, LAT_SELF, SCAN_RD, SCAN_CHK, WRITE, DONE
    } state_t;
endpackage

// File: rtl/block_move_writer_rect_overlap.sv
// block_move_writer_rect_overlap: strict overlap test between two block footprints
module block_move_writer_rect_overlap
    import block_move_writer_pkg::*;
#(
    parameter int BLK_LEN = BLK_LEN_DEF,
    parameter int BLK_W   = BLK_W_DEF
) (
    input  logic [8:0] ax,
    input  logic [8:0] ay,
    input  logic       a_orient,
    input  logic [8:0] bx,
    input  logic [8:0] by,
    input  logic       b_orient,
    output logic       overlap
);
    localparam logic [8:0] L = 9'(BLK_LEN);
    localparam logic [8:0] W = 9'(BLK_W);

    logic [8:0] aw, ah, bw, bh;

    assign aw = a_orient ? W : L;
    assign ah = a_orient ? L : W;
    assign bw = b_orient ? W : L;
    assign bh = b_orient ? L : W;
    assign overlap = ax < bx + bw && bx < ax + aw && ay < by + bh && by < ay + ah;
endmodule

// File: rtl/block_move_writer.sv
// block_move_writer: bounds- and collision-checked move of one block record in the shared RAM
module block_move_writer
    import block_move_writer_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int STEP       = STEP_DEF,
    parameter int BLK_LEN    = BLK_LEN_DEF,
    parameter int BLK_W      = BLK_W_DEF,
    parameter int GRID_X0    = GRID_X0_DEF,
    parameter int GRID_X1    = GRID_X1_DEF,
    parameter int GRID_Y0    = GRID_Y0_DEF,
    parameter int GRID_Y1    = GRID_Y1_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_index,
    input  logic        req_dir,
    output logic        done,
    output logic [1:0]  done_status,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [4:0]  mem_address,
    output logic [19:0] mem_data,
    output logic        mem_wren,
    input  logic [19:0] mem_q
);
    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [8:0] LEN9  = 9'(BLK_LEN);
    localparam logic [8:0] X0    = 9'(GRID_X0);
    localparam logic [8:0] X1    = 9'(GRID_X1);
    localparam logic [8:0] Y0    = 9'(GRID_Y0);
    localparam logic [8:0] Y1    = 9'(GRID_Y1);
    localparam logic [4:0] LAST  = 5'(NUM_BLOCKS - 1);

    state_t     state, state_nx;
    status_t    status_q, status_nx;
    record_t    rec, moved_q, moved_nx;
    logic [3:0] index;
    logic       dir;
    logic [4:0] scan_addr, scan_nx;
    logic [8:0] pos, cand, lo, hi;
    logic       in_bounds, slot_bad, skip, hit, unused_pad;

    assign rec        = record_t'(mem_q);
    assign unused_pad = rec.pad;

    // Candidate position along the long axis, 9-bit so a borrow below zero is detectable
    assign pos       = rec.orient ? {2'b0, rec.y} : {1'b0, rec.x};
    assign cand      = dir ? pos + STEP9 : pos - STEP9;
    assign lo        = rec.orient ? Y0 : X0;
    assign hi        = rec.orient ? Y1 : X1;
    assign in_bounds = (dir || pos >= STEP9) && cand >= lo && cand + LEN9 <= hi;
    assign slot_bad  = rec.colour == EMPTY_COLOUR || {1'b0, index} >= 5'(NUM_BLOCKS);
    assign moved_nx  = '{pad: 1'b0, colour: rec.colour, orient: rec.orient,
                         y: rec.orient ? cand[6:0] : rec.y,
                         x: rec.orient ? rec.x : cand[7:0]};
    assign skip      = scan_addr == {1'b0, index} || rec.colour == EMPTY_COLOUR;

    block_move_writer_rect_overlap #(.BLK_LEN(BLK_LEN), .BLK_W(BLK_W)) u_overlap (
        .ax      ({1'b0, moved_q.x}),
        .ay      ({2'b0, moved_q.y}),
        .a_orient(moved_q.orient),
        .bx      ({1'b0, rec.x}),
        .by      ({2'b0, rec.y}),
        .b_orient(rec.orient),
        .overlap (hit)
    );

    // Next state; losing the grant anywhere between RD_SELF and WRITE restarts from arbitration
    always_comb begin
        state_nx  = state;
        status_nx = status_q;
        scan_nx   = scan_addr;
        case (state)
            IDLE:     state_nx = req_valid ? ARB : IDLE;
            ARB:      state_nx = mem_gnt ? RD_SELF : ARB;
            RD_SELF:  state_nx = mem_gnt ? LAT_SELF : ARB;
            LAT_SELF: begin
                if (!mem_gnt) state_nx = ARB;
                else if (slot_bad) begin
                    state_nx  = DONE;
                    status_nx = STATUS_EMPTY;
                end else if (!in_bounds) begin
                    state_nx  = DONE;
                    status_nx = STATUS_EDGE;
                end else begin
                    state_nx = SCAN_RD;
                    scan_nx  = 5'd0;
                end
            end
            SCAN_RD:  state_nx = mem_gnt ? SCAN_CHK : ARB;
            SCAN_CHK: begin
                if (!mem_gnt) state_nx = ARB;
                else if (!skip && hit) begin
                    state_nx  = DONE;
                    status_nx = STATUS_COLLIDE;
                end else if (scan_addr == LAST) state_nx = WRITE;
                else begin
                    state_nx = SCAN_RD;
                    scan_nx  = scan_addr + 5'd1;
                end
            end
            WRITE: begin
                state_nx  = mem_gnt ? DONE : ARB;
                status_nx = mem_gnt ? STATUS_MOVED : status_q;
            end
            DONE:     state_nx = IDLE;
        endcase
    end

    // State, scan pointer, latched request and the rewritten record
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            status_q  <= STATUS_MOVED;
            scan_addr <= 5'd0;
            index     <= 4'd0;
            dir       <= 1'b0;
            moved_q   <= '0;
        end else begin
            state     <= state_nx;
            status_q  <= status_nx;
            scan_addr <= scan_nx;
            if (state == IDLE && req_valid) begin
                index <= req_index;
                dir   <= req_dir;
            end
            if (state == LAT_SELF) moved_q <= moved_nx;
        end
    end

    assign req_ready   = state == IDLE;
    assign done        = state == DONE;
    assign done_status = status_q;
    assign mem_req     = !(state == IDLE || state == DONE);
    assign mem_address = (state == RD_SELF || state == WRITE) ? {1'b0, index} :
                         state == SCAN_RD ? scan_addr : 5'd0;
    assign mem_wren    = state == WRITE && mem_gnt;
    assign mem_data    = mem_wren ? moved_q : 20'd0;
endmodule

// File: tb/tb_block_move_writer.sv
// tb_block_move_writer: directed moves against a RAM model, scoreboarded on done and write strobes
module tb_block_move_writer;
    import block_move_writer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_dir = 1'b0;
    logic [3:0]  req_index = 4'd0;
    logic        done, mem_req, mem_gnt = 1'b1, mem_wren;
    logic [1:0]  done_status;
    logic [4:0]  mem_address;
    logic [19:0] mem_data, mem_q;

    logic        v8 = 1'b0, rdy8, dir8 = 1'b0, done8, mreq8, wren8;
    logic [3:0]  idx8 = 4'd0;
    logic [1:0]  st8;
    logic [4:0]  addr8;
    logic [19:0] data8, q8;

    logic [19:0] ram [32];
    logic [4:0]  aq = 5'd0, aq8 = 5'd0;
    logic        tb_we = 1'b0;
    logic [4:0]  tb_addr = 5'd0;
    logic [19:0] tb_data = 20'd0;

    int passed = 0, total = 0;
    logic [1:0]  exp_st [$];
    logic [24:0] exp_wr [$];

    always #5 clk = ~clk;

    block_move_writer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_dir(req_dir), .done(done), .done_status(done_status),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_address(mem_address),
        .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    block_move_writer #(.NUM_BLOCKS(8)) dut8 (
        .clk(clk), .reset(reset), .req_valid(v8), .req_ready(rdy8),
        .req_index(idx8), .req_dir(dir8), .done(done8), .done_status(st8),
        .mem_req(mreq8), .mem_gnt(1'b1), .mem_address(addr8),
        .mem_data(data8), .mem_wren(wren8), .mem_q(q8)
    );

    // Single-port RAM with registered address; the bench loads it through its own port
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        else if (tb_we) ram[tb_addr] <= tb_data;
        aq  <= mem_address;
        aq8 <= addr8;
    end
    assign mem_q = ram[aq];
    assign q8    = ram[aq8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [19:0] mkrec(int x, int y, bit o, int c);
        return {1'b0, 3'(c), o, 7'(y), 8'(x)};
    endfunction

    // Monitor: every done pulse and every write strobe is matched against the scoreboard
    always @(negedge clk) begin
        if (done) begin
            if (exp_st.size() == 0) chk("unexpected done", 32'(done_status), 32'hFF);
            else chk("done_status", 32'(done_status), 32'(exp_st.pop_front()));
        end
        if (mem_wren) begin
            if (!mem_gnt) chk("write without gnt", 32'(mem_gnt), 32'd1);
            if (exp_wr.size() == 0) chk("unexpected write", {7'b0, mem_address, mem_data}, 32'hFFFFFFFF);
            else chk("write addr/data", {7'b0, mem_address, mem_data}, {7'b0, exp_wr.pop_front()});
        end
        if (wren8) chk("dut8 write", 32'(wren8), 32'd0);
    end

    task automatic poke(input int a, input logic [19:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_addr = 5'(a);
        tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 32; i++) poke(i, 20'd0);
    endtask

    task automatic start(input int idx, input bit dir);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_index = 4'(idx);
        req_dir = dir;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_index = 4'hF;
        req_dir = ~dir;
    endtask

    task automatic wait_done(input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 300);
        if (!done) chk("done timeout", 32'(done), 32'd1);
        else if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic request(input int idx, input bit dir, input status_t st, input bit wr,
                           input logic [19:0] wdata, input int lat);
        exp_st.push_back(st);
        if (wr) exp_wr.push_back({5'(idx), wdata});
        start(idx, dir);
        wait_done(lat);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " done_status"}, 32'(done_status), 32'd0);
        chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " mem_wren"}, 32'(mem_wren), 32'd0);
        chk({tag, " mem_address"}, 32'(mem_address), 32'd0);
        chk({tag, " mem_data"}, 32'(mem_data), 32'd0);
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        #2 check_reset_outputs("reset");
        #4 reset = 1'b1;
        clear_ram();

        poke(0, mkrec(49, 49, 0, 3));
        request(0, 1, STATUS_MOVED, 1, mkrec(60, 49, 0, 3), 37);
        chk("record bits 19:15", 32'(ram[0][19:15]), 32'h06);

        poke(0, mkrec(49, 49, 0, 3));
        request(0, 0, STATUS_EDGE, 0, 20'd0, 4);

        poke(1, mkrec(60, 49, 1, 2));
        request(0, 1, STATUS_COLLIDE, 0, 20'd0, 8);

        poke(1, mkrec(71, 49, 1, 2));
        request(0, 1, STATUS_MOVED, 1, mkrec(60, 49, 0, 3), 37);

        request(5, 1, STATUS_EMPTY, 0, 20'd0, 4);

        poke(9, mkrec(49, 49, 0, 5));
        chk("dut8 ready", 32'(rdy8), 32'd1);
        v8 = 1'b1;
        idx8 = 4'd9;
        dir8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 50);
        chk("dut8 done seen", 32'(done8), 32'd1);
        chk("dut8 status", 32'(st8), 32'(STATUS_EMPTY));
        chk("dut8 latency", 32'(n), 32'd4);

        clear_ram();
        poke(2, mkrec(49, 49, 0, 3));
        exp_st.push_back(STATUS_MOVED);
        exp_wr.push_back({5'd2, mkrec(60, 49, 0, 3)});
        start(2, 1);
        repeat (10) @(negedge clk);
        mem_gnt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mem_req held", 32'(mem_req), 32'd1);
            chk("no wren without gnt", 32'(mem_wren), 32'd0);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("reread self addr", 32'(mem_address), 32'd2);
        repeat (2) @(negedge clk);
        chk("scan restart addr0", 32'(mem_address), 32'd0);
        repeat (2) @(negedge clk);
        chk("scan addr1", 32'(mem_address), 32'd1);
        wait_done(0);

        request(5, 1, STATUS_EMPTY, 0, 20'd0, 4);
        chk("ram2 before abort", 32'(ram[2]), 32'(mkrec(60, 49, 0, 3)));
        start(2, 1);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        #2 reset = 1'b1;
        chk("ram2 after abort", 32'(ram[2]), 32'(mkrec(60, 49, 0, 3)));
        request(2, 1, STATUS_MOVED, 1, mkrec(71, 49, 0, 3), 37);

        repeat (3) @(negedge clk);
        chk("status queue empty", 32'(exp_st.size()), 32'd0);
        chk("write queue empty", 32'(exp_wr.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
